// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding select codes, shadow-stage records and forwarding priority helper
package fwd_pkg;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  typedef struct packed {
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic we;
    logic mr;
  } ex_stage_t;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic we;
    logic mr;
  } mem_stage_t;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic we;
  } wb_stage_t;
  function automatic fwd_sel_e fwd_sel(input mem_stage_t m, input wb_stage_t w, input logic [ADDR_W-1:0] r);
    return (m.we && m.rd != REG_ZERO && m.rd == r) ? FWD_MEM :
           (w.we && w.rd != REG_ZERO && w.rd == r) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/fwd_stage_reg.sv
// fwd_stage_reg: shadow pipeline stage register with hold, bubble insert and sync reset
module fwd_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : hold ? q : bubble ? '0 : d;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX forwarding selects and load-use stall; FWD_PERF_CNT_EN adds saturating stall/forward counters
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = ADDR_W
`ifdef FWD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                  clock__i,
  input  logic                  reset__i,
  input  logic [REG_ADDR_W-1:0] idRs__i,
  input  logic [REG_ADDR_W-1:0] idRt__i,
  input  logic [REG_ADDR_W-1:0] idRd__i,
  input  logic                  idRegWrite__i,
  input  logic                  idMemRead__i,
  input  logic                  flush__i,
  input  logic                  freeze__i,
  output logic [1:0]            fwdSelA__o,
  output logic [1:0]            fwdSelB__o,
  output logic                  stall__o
`ifdef FWD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stallCnt__o
  , output logic [CNT_W-1:0]    fwdCnt__o
`endif
);
  ex_stage_t ex_d, ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t wb_d, wb_q;
  assign ex_d = '{rs: idRs__i, rt: idRt__i, rd: idRd__i, we: idRegWrite__i, mr: idMemRead__i};
  assign mem_d = '{rd: ex_q.rd, we: ex_q.we, mr: ex_q.mr};
  assign wb_d = '{rd: mem_q.rd, we: mem_q.we};
  assign stall__o = ex_q.mr && ex_q.rd != REG_ZERO && (ex_q.rd == idRs__i || ex_q.rd == idRt__i) && !flush__i;
  assign fwdSelA__o = fwd_sel(mem_q, wb_q, ex_q.rs);
  assign fwdSelB__o = fwd_sel(mem_q, wb_q, ex_q.rt);
  fwd_stage_reg #(.W($bits(ex_stage_t))) u_ex (
    .clk(clock__i), .rst(reset__i), .hold(freeze__i), .bubble(stall__o || flush__i), .d(ex_d), .q(ex_q)
  );
  fwd_stage_reg #(.W($bits(mem_stage_t))) u_mem (
    .clk(clock__i), .rst(reset__i), .hold(freeze__i), .bubble(1'b0), .d(mem_d), .q(mem_q)
  );
  fwd_stage_reg #(.W($bits(wb_stage_t))) u_wb (
    .clk(clock__i), .rst(reset__i), .hold(freeze__i), .bubble(1'b0), .d(wb_d), .q(wb_q)
  );
`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      stallCnt__o <= '0;
      fwdCnt__o <= '0;
    end else if (!freeze__i) begin
      if (stall__o && !(&stallCnt__o)) stallCnt__o <= stallCnt__o + 1'b1;
      if ((|fwdSelA__o || |fwdSelB__o) && !(&fwdCnt__o)) fwdCnt__o <= fwdCnt__o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed pipeline vectors plus randomized run against an instruction-history model
module tb_fwd_hazard_unit;
  typedef struct {
    logic [4:0] rs, rt, rd;
    logic we, mr, fl, fz, rst;
    logic [1:0] ea, eb;
    logic es;
  } vec_t;
  typedef struct {
    logic [4:0] rs, rt, rd;
    logic we, mr;
  } ins_t;
  logic clk = 1'b0;
  logic rst, flush, freeze, we, mr;
  logic [4:0] rs, rt, rd;
  logic [1:0] sel_a, sel_b;
  logic stall;
  int checks = 0;
  int errors = 0;
  ins_t pipe[3];
  vec_t tv[34];
`ifdef FWD_PERF_CNT_EN
  logic [31:0] scnt, fcnt;
  int m_scnt = 0;
  int m_fcnt = 0;
`endif
  always #5 clk = ~clk;
  fwd_hazard_unit dut (
    .clock__i(clk), .reset__i(rst), .idRs__i(rs), .idRt__i(rt), .idRd__i(rd),
    .idRegWrite__i(we), .idMemRead__i(mr), .flush__i(flush), .freeze__i(freeze),
    .fwdSelA__o(sel_a), .fwdSelB__o(sel_b), .stall__o(stall)
`ifdef FWD_PERF_CNT_EN
    , .stallCnt__o(scnt), .fwdCnt__o(fcnt)
`endif
  );
  function automatic vec_t mk(int rs_, int rt_, int rd_, bit we_, bit mr_, bit fl_, bit fz_, bit rst_,
                              int ea_, int eb_, bit es_);
    vec_t v;
    v.rs = 5'(rs_); v.rt = 5'(rt_); v.rd = 5'(rd_);
    v.we = we_; v.mr = mr_; v.fl = fl_; v.fz = fz_; v.rst = rst_;
    v.ea = 2'(ea_); v.eb = 2'(eb_); v.es = es_;
    return v;
  endfunction
  function automatic logic [1:0] m_sel(logic [4:0] r);
    for (int k = 1; k <= 2; k++)
      if (pipe[k].we && pipe[k].rd != 0 && pipe[k].rd == r) return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction
  function automatic logic m_stall();
    return pipe[0].mr && pipe[0].rd != 0 && (pipe[0].rd == rs || pipe[0].rd == rt) && !flush;
  endfunction
  task automatic drive(vec_t v);
    @(negedge clk);
    rs = v.rs; rt = v.rt; rd = v.rd; we = v.we; mr = v.mr;
    flush = v.fl; freeze = v.fz; rst = v.rst;
    #1;
  endtask
  task automatic check(string nm, logic [1:0] a, logic [1:0] b, logic s);
    checks += 3;
    if (sel_a !== a) begin errors++; $display("FAIL %s selA: got %b expected %b", nm, sel_a, a); end
    if (sel_b !== b) begin errors++; $display("FAIL %s selB: got %b expected %b", nm, sel_b, b); end
    if (stall !== s) begin errors++; $display("FAIL %s stall: got %b expected %b", nm, stall, s); end
  endtask
  task automatic model_edge();
    logic st;
    ins_t id;
    st = m_stall();
    id = '{rs: rs, rt: rt, rd: rd, we: we, mr: mr};
`ifdef FWD_PERF_CNT_EN
    if (rst) begin m_scnt = 0; m_fcnt = 0; end
    else if (!freeze) begin
      m_scnt += int'(st);
      m_fcnt += int'(m_sel(pipe[0].rs) != 0 || m_sel(pipe[0].rt) != 0);
    end
`endif
    @(posedge clk);
    if (rst) for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
    else if (!freeze) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (flush || st) ? '{default: '0} : id;
    end
  endtask
  initial begin
    vec_t v;
    tv[0]  = mk(0,0,0, 0,0,0,0,1, 0,0,0);
    tv[1]  = mk(1,2,3, 1,0,0,0,0, 0,0,0);
    tv[2]  = mk(3,5,4, 1,0,0,0,0, 0,0,0);
    tv[3]  = mk(0,0,0, 0,0,0,0,0, 2,0,0);
    tv[4]  = mk(1,2,3, 1,0,0,0,0, 0,0,0);
    tv[5]  = mk(0,0,0, 0,0,0,0,0, 0,0,0);
    tv[6]  = mk(7,3,6, 1,0,0,0,0, 0,0,0);
    tv[7]  = mk(0,0,0, 0,0,0,0,0, 0,1,0);
    tv[8]  = mk(1,0,2, 1,1,0,0,0, 0,0,0);
    tv[9]  = mk(2,2,8, 1,0,0,0,0, 0,0,1);
    tv[10] = mk(2,2,8, 1,0,0,0,0, 0,0,0);
    tv[11] = mk(0,0,0, 0,0,0,0,0, 1,1,0);
    tv[12] = mk(1,1,0, 1,0,0,0,0, 0,0,0);
    tv[13] = mk(0,0,9, 1,0,0,0,0, 0,0,0);
    tv[14] = mk(0,0,0, 0,0,0,0,0, 0,0,0);
    tv[15] = mk(1,0,2, 1,1,0,0,0, 0,0,0);
    tv[16] = mk(2,3,10,1,0,1,0,0, 0,0,0);
    tv[17] = mk(0,0,0, 0,0,0,0,0, 0,0,0);
    tv[18] = mk(1,0,5, 1,1,0,0,0, 0,0,0);
    tv[19] = mk(5,5,12,1,0,0,1,0, 0,0,1);
    tv[20] = mk(5,5,12,1,0,0,1,0, 0,0,1);
    tv[21] = mk(5,5,12,1,0,0,1,0, 0,0,1);
    tv[22] = mk(5,5,12,1,0,0,0,0, 0,0,1);
    tv[23] = mk(5,5,12,1,0,0,0,0, 0,0,0);
    tv[24] = mk(0,0,0, 0,0,0,1,0, 1,1,0);
    tv[25] = mk(0,0,0, 0,0,0,1,0, 1,1,0);
    tv[26] = mk(0,0,0, 0,0,0,0,0, 1,1,0);
    tv[27] = mk(1,0,7, 1,1,0,0,0, 0,0,0);
    tv[28] = mk(7,0,13,1,0,0,0,1, 0,0,1);
    tv[29] = mk(7,0,13,1,0,0,0,0, 0,0,0);
    tv[30] = mk(0,0,3, 1,0,0,0,0, 0,0,0);
    tv[31] = mk(0,0,3, 1,0,0,0,0, 0,0,0);
    tv[32] = mk(3,3,14,1,0,0,0,0, 0,0,0);
    tv[33] = mk(0,0,0, 0,0,0,0,0, 2,2,0);
    drive(mk(0,0,0, 0,0,0,0,1, 0,0,0));
    model_edge();
    for (int i = 0; i < 34; i++) begin
      drive(tv[i]);
      check($sformatf("vec%0d", i), tv[i].ea, tv[i].eb, tv[i].es);
      model_edge();
    end
    for (int i = 0; i < 3000; i++) begin
      v = mk($urandom_range(7), $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)),
             $urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
             $urandom_range(63) == 0, 0, 0, 0);
      drive(v);
      check($sformatf("rand%0d", i), m_sel(pipe[0].rs), m_sel(pipe[0].rt), m_stall());
      model_edge();
    end
`ifdef FWD_PERF_CNT_EN
    #1;
    checks += 2;
    if (scnt !== 32'(m_scnt)) begin errors++; $display("FAIL stallCnt: got %0d expected %0d", scnt, m_scnt); end
    if (fcnt !== 32'(m_fcnt)) begin errors++; $display("FAIL fwdCnt: got %0d expected %0d", fcnt, m_fcnt); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
